ddr_cmd_scheduler: RTL and testbench
====================================

# ddr_cmd_scheduler

Host-side command scheduler for the DDR controller's command interface. After reset, it runs the mandatory configuration and initialisation sequence: LOAD_REG1, LOAD_REG2, PRECHARGE, two REFRESHes, then LOAD_MODE. It then arbitrates round-robin between two read/write requester ports. Each selected access is presented as a CMD/ADDR pair, held until the command interface returns CMD_ACK.

## Interface
Parameters:
- ASIZE, 22, address width; must match the controller address width.
- INIT_WAIT, 200, power-up wait in cycles before the first command. 16-bit.
- REG1_VAL, 22'h000_0E15, LOAD_REG1 payload: CL=1, RC=1, RRD=1, PM=0, BL=7.
- REG2_VAL, 22'h000_0618, LOAD_REG2 payload (refresh period).
- PRE_ADDR, 22'h000_0400, PRECHARGE address (all banks).
- MODE_VAL, 22'h000_0023, LOAD_MODE address.
- ACK_TIMEOUT, 255, maximum cycles to wait for CMD_ACK. 8-bit.

Ports:
- CLK in 1: system clock.
- RESET in 1: reset. One clock; reset is synchronous and active-high.
- CMD_ACK in 1: one-cycle command acknowledge from the command interface.
- P0_REQ, P1_REQ in 1: access requests.
- P0_WR, P1_WR in 1: 1 = WRITEA, 0 = READA.
- P0_ADDR, P1_ADDR in ASIZE: access addresses.
- P0_ACK, P1_ACK out 1: one-cycle acceptance pulse.
- CMD out 3: encoded command to the command interface.
- ADDR out ASIZE: address/payload aligned with CMD.
- INIT_DONE out 1: high once initialisation has completed.
- ERR out 1: sticky flag, set on any ack timeout.

## Operation
Command encoding:
- 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH.
- 100 PRECHARGE, 101 LOAD_MODE, 110 LOAD_REG1, 111 LOAD_REG2.

Reset values (every output is registered):
- CMD=000, ADDR=0.
- P0_ACK=P1_ACK=0, INIT_DONE=0, ERR=0.
- state=PWRUP, step=0, rr pointer=port 0.

States:
- PWRUP: 16-bit counter counts INIT_WAIT cycles, driving NOP, then goes to ICMD.
- ICMD:
  - Drives CMD/ADDR for init step 0..5: LOAD_REG1/REG1_VAL, LOAD_REG2/REG2_VAL, PRECHARGE/PRE_ADDR, REFRESH/0, REFRESH/0, LOAD_MODE/MODE_VAL.
  - LOAD_REG1 goes first so the controller's refresh timer starts only after BL is programmed.
  - Holds CMD/ADDR until CMD_ACK=1, then goes to IGAP.
- IGAP:
  - Drives NOP for one cycle and increments step.
  - If step was 5: sets INIT_DONE and goes to IDLE; otherwise returns to ICMD.
- IDLE:
  - Drives NOP.
  - If any REQ is set, the arbiter picks a port and the scheduler latches its WR/ADDR into CMD/ADDR, then goes to ACC.
  - Round-robin rule: the port that did not win last has priority when both request.
- ACC:
  - Holds CMD/ADDR until CMD_ACK=1.
  - On CMD_ACK: CMD returns to NOP, the granted port's ACK pulses high, the rr pointer toggles, and the state goes to GAP.
- GAP: one NOP cycle, then IDLE. This gives the requester a cycle to drop or change REQ after its ACK.

Requester rules:
- Hold REQ/WR/ADDR stable until ACK is seen.
- ADDR is captured when the grant is taken. Later changes are ignored for the in-flight command.
- Dropping REQ before ACK is illegal, except while the state is IDLE.

Ack timeout:
- An 8-bit counter is cleared on entry to ICMD or ACC.
- If it reaches ACK_TIMEOUT without CMD_ACK:
  - ERR <= 1 (sticky until RESET).
  - CMD <= NOP, no ACK pulse.
  - From ICMD: go to IGAP without incrementing step (retry).
  - From ACC: go to GAP; the request is re-arbitrated normally.
- CMD_ACK in the same cycle the counter expires counts as an ack.
- CMD_ACK outside ICMD/ACC is ignored.

Reset asserted in any state aborts immediately. The next edge gives reset values, and the full init sequence reruns, including INIT_WAIT.

## Timing
- Requester request:
  - REQ is sampled in IDLE at edge t.
  - CMD/ADDR are valid from t to t+1 onward.
- Acknowledge:
  - CMD_ACK is sampled high at edge a.
  - After a: CMD=NOP and Pn_ACK=1.
  - After a+1: Pn_ACK=0 and the state is IDLE.
  - The earliest next command is after edge a+2, so there are at least 2 NOP cycles between commands.
- Init:
  - The first LOAD_REG1 appears INIT_WAIT+1 cycles after reset release.
  - INIT_DONE rises the cycle after the LOAD_MODE ack.
  - Requests arriving before INIT_DONE are held off (no grant).

## Structure
- Shared package ddr_cmd_pkg:
  - 3-bit command encodings.
  - State enum: PWRUP, ICMD, IGAP, IDLE, ACC, GAP.
  - Init-step count constant (6).
- Sub-module ddr_rr_arbiter:
  - 2-port round-robin arbiter, combinational grant from REQ plus the pointer.
  - The pointer update is driven by the scheduler on accept.

## Test plan
- Reset, INIT_WAIT=4, bench acks each command 3 cycles after it appears -> CMD sequence 110,111,100,011,011,101 with ADDR=REG1_VAL,REG2_VAL,0x400,0,0,0x23; ≥1 NOP between commands; INIT_DONE=1 after the last ack.
- After init, P0_REQ=1, P0_WR=1, P0_ADDR=0x12345, ack 2 cycles later -> CMD=010, ADDR=0x12345 held until ack; P0_ACK pulses exactly one cycle; ERR=0.
- P0 and P1 both requesting continuously (reads), acks immediate -> grants alternate P0,P1,P0,P1; CMD=001 each time; 2 NOP cycles between commands.
- ACK_TIMEOUT=8, no CMD_ACK during the first LOAD_REG2 -> after 8 cycles NOP, ERR=1, LOAD_REG2 reissued; ack it -> sequence resumes and INIT_DONE still reaches 1.
- RESET pulsed mid-access (ACC) -> next cycle CMD=000, INIT_DONE=0, no ACK pulse; the sequence restarts from PWRUP with LOAD_REG1 first.
- P1_REQ asserted before INIT_DONE -> no READA/WRITEA issued until the cycle after INIT_DONE; then granted.

Source files
------------

// File: rtl/ddr_cmd_pkg.sv
// ddr_cmd_pkg: command encodings, scheduler states and init-sequence helpers
package ddr_cmd_pkg;
  localparam logic [2:0] CMD_NOP       = 3'b000;
  localparam logic [2:0] CMD_READA     = 3'b001;
  localparam logic [2:0] CMD_WRITEA    = 3'b010;
  localparam logic [2:0] CMD_REFRESH   = 3'b011;
  localparam logic [2:0] CMD_PRECHARGE = 3'b100;
  localparam logic [2:0] CMD_LOAD_MODE = 3'b101;
  localparam logic [2:0] CMD_LOAD_REG1 = 3'b110;
  localparam logic [2:0] CMD_LOAD_REG2 = 3'b111;
  localparam logic [2:0] INIT_STEPS    = 3'd6;
  typedef enum logic [2:0] {PWRUP, ICMD, IGAP, IDLE, ACC, GAP} state_t;
  function automatic logic [2:0] init_cmd(input logic [2:0] step);
    return step == 3'd0 ? CMD_LOAD_REG1 :
           step == 3'd1 ? CMD_LOAD_REG2 :
           step == 3'd2 ? CMD_PRECHARGE :
           step == 3'd5 ? CMD_LOAD_MODE : CMD_REFRESH;
  endfunction
endpackage

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: two-port round-robin grant; ptr names the port with priority on a tie
module ddr_rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic req_any,
  output logic gnt
);
  assign req_any = req0 | req1;
  assign gnt     = (req0 & req1) ? ptr : req1;
endmodule

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: runs the DDR init sequence, then schedules two requester ports onto CMD/ADDR
module ddr_cmd_scheduler
  import ddr_cmd_pkg::*;
#(
  parameter int              ASIZE       = 22,
  parameter logic [15:0]     INIT_WAIT   = 16'd200,
  parameter logic [ASIZE-1:0] REG1_VAL   = ASIZE'(22'h000_0E15),
  parameter logic [ASIZE-1:0] REG2_VAL   = ASIZE'(22'h000_0618),
  parameter logic [ASIZE-1:0] PRE_ADDR   = ASIZE'(22'h000_0400),
  parameter logic [ASIZE-1:0] MODE_VAL   = ASIZE'(22'h000_0023),
  parameter logic [7:0]      ACK_TIMEOUT = 8'd255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_ACK,
  input  logic             P0_REQ,
  input  logic             P1_REQ,
  input  logic             P0_WR,
  input  logic             P1_WR,
  input  logic [ASIZE-1:0] P0_ADDR,
  input  logic [ASIZE-1:0] P1_ADDR,
  output logic             P0_ACK,
  output logic             P1_ACK,
  output logic [2:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  output logic             INIT_DONE,
  output logic             ERR
);
  localparam logic [7:0] TO_LAST = ACK_TIMEOUT - 8'd1;
  state_t state, state_n;
  logic [2:0] step, step_n;
  logic [15:0] wcnt, wcnt_n;
  logic [7:0] tcnt, tcnt_n;
  logic ptr, ptr_n, gnt_q, gnt_n, req_any, gnt;
  logic [2:0] cmd_n;
  logic [ASIZE-1:0] addr_n, init_addr;
  logic p0_ack_n, p1_ack_n, done_n, err_n;
  ddr_rr_arbiter u_arb (
    .req0(P0_REQ), .req1(P1_REQ), .ptr(ptr), .req_any(req_any), .gnt(gnt)
  );
  assign init_addr = step == 3'd0 ? REG1_VAL :
                     step == 3'd1 ? REG2_VAL :
                     step == 3'd2 ? PRE_ADDR :
                     step == 3'd5 ? MODE_VAL : '0;
  // next-state and next-output decode; every output is registered below
  always_comb begin
    state_n  = state;
    step_n   = step;
    wcnt_n   = wcnt;
    tcnt_n   = tcnt;
    ptr_n    = ptr;
    gnt_n    = gnt_q;
    cmd_n    = CMD;
    addr_n   = ADDR;
    p0_ack_n = 1'b0;
    p1_ack_n = 1'b0;
    done_n   = INIT_DONE;
    err_n    = ERR;
    case (state)
      PWRUP: begin
        wcnt_n = wcnt + 16'd1;
        if (wcnt == INIT_WAIT) begin
          state_n = ICMD;
          cmd_n   = init_cmd(step);
          addr_n  = init_addr;
          tcnt_n  = '0;
        end
      end
      ICMD: begin
        tcnt_n = tcnt + 8'd1;
        if (CMD_ACK || tcnt == TO_LAST) begin
          state_n = IGAP;
          cmd_n   = CMD_NOP;
          addr_n  = '0;
          step_n  = CMD_ACK ? step + 3'd1 : step;
          err_n   = ERR | ~CMD_ACK;
        end
      end
      IGAP: begin
        state_n = step == INIT_STEPS ? IDLE : ICMD;
        done_n  = step == INIT_STEPS;
        cmd_n   = step == INIT_STEPS ? CMD_NOP : init_cmd(step);
        addr_n  = step == INIT_STEPS ? '0 : init_addr;
        tcnt_n  = '0;
      end
      IDLE: begin
        if (req_any) begin
          state_n = ACC;
          gnt_n   = gnt;
          cmd_n   = (gnt ? P1_WR : P0_WR) ? CMD_WRITEA : CMD_READA;
          addr_n  = gnt ? P1_ADDR : P0_ADDR;
          tcnt_n  = '0;
        end
      end
      ACC: begin
        tcnt_n = tcnt + 8'd1;
        if (CMD_ACK || tcnt == TO_LAST) begin
          state_n  = GAP;
          cmd_n    = CMD_NOP;
          addr_n   = '0;
          p0_ack_n = CMD_ACK & ~gnt_q;
          p1_ack_n = CMD_ACK & gnt_q;
          ptr_n    = CMD_ACK ? ~gnt_q : ptr;
          err_n    = ERR | ~CMD_ACK;
        end
      end
      GAP: state_n = IDLE;
      default: state_n = PWRUP;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= PWRUP;
      step      <= '0;
      wcnt      <= '0;
      tcnt      <= '0;
      ptr       <= 1'b0;
      gnt_q     <= 1'b0;
      CMD       <= CMD_NOP;
      ADDR      <= '0;
      P0_ACK    <= 1'b0;
      P1_ACK    <= 1'b0;
      INIT_DONE <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      wcnt      <= wcnt_n;
      tcnt      <= tcnt_n;
      ptr       <= ptr_n;
      gnt_q     <= gnt_n;
      CMD       <= cmd_n;
      ADDR      <= addr_n;
      P0_ACK    <= p0_ack_n;
      P1_ACK    <= p1_ack_n;
      INIT_DONE <= done_n;
      ERR       <= err_n;
    end
  end
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb_ddr_cmd_scheduler: directed and randomized checks of init sequence, arbitration and timeouts
module tb_ddr_cmd_scheduler;
  localparam int AW = 22;
  localparam logic [15:0] IW = 16'd4;
  localparam logic [7:0] TO = 8'd8;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic CMD_ACK = 1'b0;
  logic P0_REQ = 1'b0, P1_REQ = 1'b0, P0_WR = 1'b0, P1_WR = 1'b0;
  logic [AW-1:0] P0_ADDR = '0, P1_ADDR = '0;
  logic P0_ACK, P1_ACK, INIT_DONE, ERR;
  logic [2:0] CMD;
  logic [AW-1:0] ADDR;
  int total = 0;
  int bad = 0;
  int last = 1;
  logic [2:0] init_c [6] = '{3'b110, 3'b111, 3'b100, 3'b011, 3'b011, 3'b101};
  logic [AW-1:0] init_a [6] = '{22'h000E15, 22'h000618, 22'h000400, 22'h0, 22'h0, 22'h000023};

  ddr_cmd_scheduler #(.ASIZE(AW), .INIT_WAIT(IW), .ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_ACK(CMD_ACK),
    .P0_REQ(P0_REQ), .P1_REQ(P1_REQ), .P0_WR(P0_WR), .P1_WR(P1_WR),
    .P0_ADDR(P0_ADDR), .P1_ADDR(P1_ADDR), .P0_ACK(P0_ACK), .P1_ACK(P1_ACK),
    .CMD(CMD), .ADDR(ADDR), .INIT_DONE(INIT_DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (CMD === 3'b000 && n < 400);
    if (CMD === 3'b000) chk("cmd_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic ack_cmd(input int d, input logic [2:0] c, input logic [AW-1:0] a);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("hold_cmd", 32'(c) ^ 32'(CMD) ^ 32'(c), 32'(c));
      chk("hold_addr", 32'(ADDR), 32'(a));
    end
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk("nop_after_ack", 32'(CMD), 32'd0);
  endtask

  task automatic run_init(input int to_step);
    int n;
    for (int s = 0; s < 6; s++) begin
      wait_cmd(n);
      chk(s == 0 ? "pwrup_wait" : "init_gap", n, s == 0 ? 32'(IW) + 1 : 32'd1);
      chk("init_cmd", 32'(CMD), 32'(init_c[s]));
      chk("init_addr", 32'(ADDR), 32'(init_a[s]));
      chk("init_done_low", 32'(INIT_DONE), 32'd0);
      if (s == to_step) begin
        for (int i = 1; i < int'(TO); i++) tick();
        chk("to_hold", 32'(CMD), 32'(init_c[s]));
        chk("to_err_pre", 32'(ERR), 32'd0);
        tick();
        chk("to_nop", 32'(CMD), 32'd0);
        chk("to_err", 32'(ERR), 32'd1);
        wait_cmd(n);
        chk("retry_gap", n, 32'd1);
        chk("retry_cmd", 32'(CMD), 32'(init_c[s]));
        chk("retry_addr", 32'(ADDR), 32'(init_a[s]));
      end
      ack_cmd(3, init_c[s], init_a[s]);
    end
    chk("init_done_at_ack", 32'(INIT_DONE), 32'd0);
    tick();
    chk("init_done", 32'(INIT_DONE), 32'd1);
  endtask

  task automatic do_txn(input int d, input int exp_gap, output int w);
    int n;
    logic wr;
    logic [2:0] c;
    logic [AW-1:0] a;
    w = (P0_REQ && P1_REQ) ? 1 - last : (P1_REQ ? 1 : 0);
    wr = w == 1 ? P1_WR : P0_WR;
    a = w == 1 ? P1_ADDR : P0_ADDR;
    c = wr ? 3'b010 : 3'b001;
    wait_cmd(n);
    if (exp_gap > 0) chk("req_gap", n, exp_gap);
    chk("acc_cmd", 32'(CMD), 32'(c));
    chk("acc_addr", 32'(ADDR), 32'(a));
    if (w == 1) P1_ADDR = ~P1_ADDR; else P0_ADDR = ~P0_ADDR;
    ack_cmd(d, c, a);
    chk("p0_ack", 32'(P0_ACK), 32'(w == 0));
    chk("p1_ack", 32'(P1_ACK), 32'(w == 1));
    last = w;
  endtask

  initial begin
    int n, w;
    tick();
    tick();
    chk("rst_cmd", 32'(CMD), 32'd0);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_acks", 32'({P0_ACK, P1_ACK}), 32'd0);
    chk("rst_done", 32'(INIT_DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RESET = 1'b0;
    run_init(-1);
    P0_REQ = 1'b1; P0_WR = 1'b1; P0_ADDR = 22'h12345;
    do_txn(2, 0, w);
    P0_REQ = 1'b0;
    tick();
    chk("p0_ack_one_cycle", 32'(P0_ACK), 32'd0);
    chk("err_clean", 32'(ERR), 32'd0);
    P0_REQ = 1'b1; P1_REQ = 1'b1; P0_WR = 1'b0; P1_WR = 1'b0;
    P0_ADDR = 22'h00AAA; P1_ADDR = 22'h15555;
    for (int k = 0; k < 4; k++) do_txn(0, k == 0 ? 0 : 2, w);
    P1_REQ = 1'b0; P0_ADDR = 22'h0BEEF;
    wait_cmd(n);
    chk("accto_cmd", 32'(CMD), 32'd1);
    for (int i = 1; i < int'(TO); i++) tick();
    chk("accto_hold", 32'(CMD), 32'd1);
    chk("accto_err_pre", 32'(ERR), 32'd0);
    tick();
    chk("accto_nop", 32'(CMD), 32'd0);
    chk("accto_noack", 32'({P0_ACK, P1_ACK}), 32'd0);
    chk("accto_err", 32'(ERR), 32'd1);
    do_txn(1, 2, w);
    P0_REQ = 1'b0; P1_REQ = 1'b1; P1_WR = 1'b1; P1_ADDR = 22'h2F0F0;
    wait_cmd(n);
    tick();
    RESET = 1'b1; CMD_ACK = 1'b1;
    tick();
    RESET = 1'b0; CMD_ACK = 1'b0;
    chk("rst2_cmd", 32'(CMD), 32'd0);
    chk("rst2_done", 32'(INIT_DONE), 32'd0);
    chk("rst2_noack", 32'({P0_ACK, P1_ACK}), 32'd0);
    chk("rst2_err", 32'(ERR), 32'd0);
    last = 1;
    P1_ADDR = 22'h1CAFE;
    run_init(1);
    do_txn(2, 1, w);
    chk("held_off_winner", w, 32'd1);
    P1_REQ = 1'($urandom_range(0, 1)); P1_WR = 1'($urandom_range(0, 1)); P1_ADDR = AW'($urandom);
    P0_REQ = 1'b1; P0_WR = 1'($urandom_range(0, 1)); P0_ADDR = AW'($urandom);
    for (int k = 0; k < 40; k++) begin
      do_txn(int'($urandom_range(0, 4)), 2, w);
      if (w == 0) begin
        P0_REQ = 1'($urandom_range(0, 1)); P0_WR = 1'($urandom_range(0, 1)); P0_ADDR = AW'($urandom);
      end else begin
        P1_REQ = 1'($urandom_range(0, 1)); P1_WR = 1'($urandom_range(0, 1)); P1_ADDR = AW'($urandom);
      end
      if (!P0_REQ && !P1_REQ) begin
        if (w == 0) P1_REQ = 1'b1; else P0_REQ = 1'b1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
